// File: rtl/pong_engine.sv
// Pong game logic: ball, paddles, scores and game phase, all stepped on frame_tick.
// Geometry and speeds are parameters; signed 12-bit arithmetic keeps off-screen candidates exact.
module pong_engine #(
    parameter int H_VIDEO      = 640,
    parameter int V_VIDEO      = 480,
    parameter int SQ_W         = 16,
    parameter int PDL_W        = 12,
    parameter int PDL_H        = 96,
    parameter int PDL1_X       = 24,
    parameter int PDL2_X       = 604,
    parameter int BALL_VX      = 4,
    parameter int MAX_VY       = 6,
    parameter int HIT_SHIFT    = 3,
    parameter int PDL_STEP     = 6,
    parameter int CPU_STEP     = 4,
    parameter int MAX_SCORE    = 11,
    parameter int SERVE_FRAMES = 120,
    parameter int ARM_CYCLES   = 2_500_000
) (
    input  logic       clk_0,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       up_p1,
    input  logic       down_p1,
    input  logic       up_p2,
    input  logic       down_p2,
    input  logic       cpu_p2,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [9:0] pdl1_y,
    output logic [9:0] pdl2_y,
    output logic       ball_shown,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic [1:0] phase,
    output logic       point_p1,
    output logic       point_p2
);
    typedef logic signed [11:0] s12_t;
    typedef enum logic [1:0] {STARTUP = 2'd0, SERVE = 2'd1, PLAY = 2'd2, OVER = 2'd3} phase_t;

    localparam logic [9:0] BALL_X0 = 10'(H_VIDEO / 2 - SQ_W / 2);
    localparam logic [9:0] BALL_Y0 = 10'(V_VIDEO / 2 - SQ_W / 2);
    localparam logic [9:0] PDL_Y0  = 10'((V_VIDEO - PDL_H) / 2);
    localparam s12_t C_VX    = s12_t'(BALL_VX);
    localparam s12_t C_SQ    = s12_t'(SQ_W);
    localparam s12_t C_HSQ   = s12_t'(SQ_W / 2);
    localparam s12_t C_PH    = s12_t'(PDL_H);
    localparam s12_t C_HPH   = s12_t'(PDL_H / 2);
    localparam s12_t C_PMAX  = s12_t'(V_VIDEO - PDL_H);
    localparam s12_t C_YMAX  = s12_t'(V_VIDEO - SQ_W);
    localparam s12_t C_XMAX  = s12_t'(H_VIDEO - SQ_W);
    localparam s12_t C_P1X   = s12_t'(PDL1_X);
    localparam s12_t C_P1R   = s12_t'(PDL1_X + PDL_W);
    localparam s12_t C_P2X   = s12_t'(PDL2_X);
    localparam s12_t C_P2R   = s12_t'(PDL2_X + PDL_W);
    localparam s12_t C_P2L   = s12_t'(PDL2_X - SQ_W);
    localparam s12_t C_MVY   = s12_t'(MAX_VY);
    localparam s12_t C_PSTEP = s12_t'(PDL_STEP);
    localparam s12_t C_CSTEP = s12_t'(CPU_STEP);
    localparam int ARM_W = $clog2(ARM_CYCLES + 1);
    localparam int SRV_W = $clog2(SERVE_FRAMES + 1);
    localparam logic [ARM_W-1:0] ARM_MAX   = ARM_W'(ARM_CYCLES);
    localparam logic [SRV_W-1:0] SRV_LAST  = SRV_W'(SERVE_FRAMES - 1);
    localparam logic [3:0]       SCORE_END = 4'(MAX_SCORE);

    function automatic s12_t ext(input logic [9:0] v);
        return s12_t'({2'b00, v});
    endfunction

    function automatic logic [9:0] clamp_pdl(input s12_t v);
        if (v[11]) return '0;
        if (v > C_PMAX) return C_PMAX[9:0];
        return v[9:0];
    endfunction

    function automatic logic [9:0] pdl_step(input logic [9:0] y, input logic up_n, input logic dn_n);
        if (!up_n && dn_n) return clamp_pdl(ext(y) - C_PSTEP);
        if (up_n && !dn_n) return clamp_pdl(ext(y) + C_PSTEP);
        return y;
    endfunction

    // Target is clamped first, so limiting the step to the remaining distance can never overshoot.
    function automatic logic [9:0] cpu_step(input logic [9:0] y, input logic [9:0] by);
        s12_t d, r;
        d = ext(clamp_pdl(ext(by) + C_HSQ - C_HPH)) - ext(y);
        if (d > C_CSTEP) d = C_CSTEP;
        else if (d < -C_CSTEP) d = -C_CSTEP;
        r = ext(y) + d;
        return r[9:0];
    endfunction

    // Returns {down, |vy|} from the ball-centre offset against the paddle centre.
    function automatic logic [10:0] deflect(input s12_t ny, input logic [9:0] py);
        s12_t off, mag;
        off = ny + C_HSQ - ext(py) - C_HPH;
        mag = off[11] ? -off : off;
        mag = mag >>> HIT_SHIFT;
        if (mag > C_MVY) mag = C_MVY;
        return {!off[11] && (off != '0), mag[9:0]};
    endfunction

    phase_t           state;
    logic             dir_r, vy_dn, released;
    logic [9:0]       vy_mag;
    logic [ARM_W-1:0] arm_cnt;
    logic [SRV_W-1:0] frame_cnt;

    s12_t       nx, ny;
    logic       ov1, ov2, hit_l, hit_r, miss_l, miss_r, nxt_dir, nxt_vy_dn, any_btn, all_high;
    logic [9:0] nxt_x, nxt_y, nxt_vy, nxt_pdl1, nxt_pdl2;
    logic [3:0] score_next;

    assign phase    = state;
    assign any_btn  = !(up_p1 && down_p1 && up_p2 && down_p2);
    assign all_high = up_p1 && down_p1 && up_p2 && down_p2;

    always_comb begin
        nxt_pdl1   = pdl_step(pdl1_y, up_p1, down_p1);
        nxt_pdl2   = cpu_p2 ? cpu_step(pdl2_y, ball_y) : pdl_step(pdl2_y, up_p2, down_p2);
        nx         = dir_r ? ext(ball_x) + C_VX : ext(ball_x) - C_VX;
        ny         = vy_dn ? ext(ball_y) + ext(vy_mag) : ext(ball_y) - ext(vy_mag);
        nxt_x      = nx[9:0];
        nxt_y      = ny[9:0];
        nxt_dir    = dir_r;
        nxt_vy     = vy_mag;
        nxt_vy_dn  = vy_dn;
        miss_l     = 1'b0;
        miss_r     = 1'b0;
        if (ny[11]) begin
            nxt_y     = '0;
            nxt_vy_dn = 1'b1;
        end else if (ny > C_YMAX) begin
            nxt_y     = C_YMAX[9:0];
            nxt_vy_dn = 1'b0;
        end
        ov1   = (ny + C_SQ > ext(pdl1_y)) && (ny < ext(pdl1_y) + C_PH);
        ov2   = (ny + C_SQ > ext(pdl2_y)) && (ny < ext(pdl2_y) + C_PH);
        hit_l = !dir_r && (nx <= C_P1R) && (nx + C_SQ > C_P1X) && ov1;
        hit_r = dir_r && (nx + C_SQ >= C_P2X) && (nx < C_P2R) && ov2;
        if (hit_l) begin
            nxt_x                 = C_P1R[9:0];
            nxt_dir               = 1'b1;
            {nxt_vy_dn, nxt_vy}   = deflect(ny, pdl1_y);
        end else if (hit_r) begin
            nxt_x                 = C_P2L[9:0];
            nxt_dir               = 1'b0;
            {nxt_vy_dn, nxt_vy}   = deflect(ny, pdl2_y);
        end else if (!dir_r && (ext(ball_x) < C_VX)) begin
            miss_l = 1'b1;
        end else if (dir_r && (nx > C_XMAX)) begin
            miss_r = 1'b1;
        end
        score_next = miss_r ? score_p1 + 4'd1 : score_p2 + 4'd1;
    end

    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            state      <= STARTUP;
            ball_x     <= BALL_X0;
            ball_y     <= BALL_Y0;
            pdl1_y     <= PDL_Y0;
            pdl2_y     <= PDL_Y0;
            ball_shown <= 1'b0;
            score_p1   <= '0;
            score_p2   <= '0;
            point_p1   <= 1'b0;
            point_p2   <= 1'b0;
            dir_r      <= 1'b0;
            vy_mag     <= '0;
            vy_dn      <= 1'b0;
            arm_cnt    <= '0;
            frame_cnt  <= '0;
            released   <= 1'b0;
        end else begin
            point_p1 <= 1'b0;
            point_p2 <= 1'b0;
            case (state)
                STARTUP: begin
                    if (arm_cnt != ARM_MAX) begin
                        arm_cnt <= arm_cnt + ARM_W'(1);
                    end else if (any_btn) begin
                        state     <= SERVE;
                        frame_cnt <= '0;
                    end
                end
                SERVE: begin
                    if (frame_tick) begin
                        pdl1_y <= nxt_pdl1;
                        pdl2_y <= nxt_pdl2;
                        if (frame_cnt == SRV_LAST) begin
                            state      <= PLAY;
                            ball_shown <= 1'b1;
                            frame_cnt  <= '0;
                        end else begin
                            frame_cnt <= frame_cnt + SRV_W'(1);
                        end
                    end
                end
                PLAY: begin
                    if (frame_tick) begin
                        pdl1_y <= nxt_pdl1;
                        pdl2_y <= nxt_pdl2;
                        if (miss_l || miss_r) begin
                            ball_x     <= BALL_X0;
                            ball_y     <= BALL_Y0;
                            ball_shown <= 1'b0;
                            vy_mag     <= '0;
                            vy_dn      <= 1'b0;
                            dir_r      <= miss_r;
                            frame_cnt  <= '0;
                            if (miss_r) begin
                                point_p1 <= 1'b1;
                                score_p1 <= score_next;
                            end else begin
                                point_p2 <= 1'b1;
                                score_p2 <= score_next;
                            end
                            state <= (score_next == SCORE_END) ? OVER : SERVE;
                        end else begin
                            ball_x <= nxt_x;
                            ball_y <= nxt_y;
                            dir_r  <= nxt_dir;
                            vy_mag <= nxt_vy;
                            vy_dn  <= nxt_vy_dn;
                        end
                    end
                end
                OVER: begin
                    if (!released) begin
                        released <= all_high;
                    end else if (any_btn) begin
                        state    <= STARTUP;
                        score_p1 <= '0;
                        score_p2 <= '0;
                        arm_cnt  <= '0;
                        released <= 1'b0;
                        pdl1_y   <= PDL_Y0;
                        pdl2_y   <= PDL_Y0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pong_engine.sv
// Directed bench for pong_engine: paddle vector table plus hand-sequenced serve, hit, miss and CPU runs.
module tb_pong_engine;
    logic       clk_0 = 1'b0;
    logic       rst, frame_tick, up_p1, down_p1, up_p2, down_p2, cpu_p2;
    logic [9:0] ball_x, ball_y, pdl1_y, pdl2_y;
    logic       ball_shown, point_p1, point_p2;
    logic [3:0] score_p1, score_p2;
    logic [1:0] phase;

    int checks = 0;
    int passes = 0;
    int n_p1 = 0;
    int n_p2 = 0;

    typedef struct {
        logic [3:0] btn;   // {up_p1, down_p1, up_p2, down_p2}, active low
        int         n;     // frame ticks to hold the buttons
        int         e1;
        int         e2;
    } vec_t;
    vec_t vecs [8];

    pong_engine #(.ARM_CYCLES(40), .MAX_SCORE(3)) dut (
        .clk_0(clk_0), .rst(rst), .frame_tick(frame_tick),
        .up_p1(up_p1), .down_p1(down_p1), .up_p2(up_p2), .down_p2(down_p2), .cpu_p2(cpu_p2),
        .ball_x(ball_x), .ball_y(ball_y), .pdl1_y(pdl1_y), .pdl2_y(pdl2_y),
        .ball_shown(ball_shown), .score_p1(score_p1), .score_p2(score_p2), .phase(phase),
        .point_p1(point_p1), .point_p2(point_p2)
    );

    always #5 clk_0 = ~clk_0;

    always @(negedge clk_0) begin
        if (point_p1) n_p1++;
        if (point_p2) n_p2++;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk_0) frame_tick = 1'b1;
        @(negedge clk_0) frame_tick = 1'b0;
    endtask

    task automatic set_btn(input logic [3:0] b);
        {up_p1, down_p1, up_p2, down_p2} = b;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ball_x"}, ball_x, 312);
        check({tag, "_ball_y"}, ball_y, 232);
        check({tag, "_pdl1"}, pdl1_y, 192);
        check({tag, "_pdl2"}, pdl2_y, 192);
        check({tag, "_scores"}, {score_p1, score_p2}, 0);
        check({tag, "_phase"}, phase, 0);
        check({tag, "_shown"}, ball_shown, 0);
        check({tag, "_points"}, {point_p1, point_p2}, 0);
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk_0) rst = 1'b0;
        #2 check_reset(tag);
        frame_tick = 1'b1;
        @(negedge clk_0) frame_tick = 1'b0;
        check_reset({tag, "_tick"});
        rst = 1'b1;
    endtask

    task automatic arm_and_serve(input string tag);
        repeat (42) @(negedge clk_0);
        up_p1 = 1'b0;
        @(negedge clk_0) up_p1 = 1'b1;
        check({tag, "_serve_phase"}, phase, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base, bad, prev, d;
        vecs[0] = '{4'b1111,  1, 192, 192};
        vecs[1] = '{4'b0111,  4, 168, 192};
        vecs[2] = '{4'b0011,  2, 168, 192};
        vecs[3] = '{4'b1110, 10, 168, 252};
        vecs[4] = '{4'b1110, 30, 168, 384};
        vecs[5] = '{4'b0111, 30,   0, 384};
        vecs[6] = '{4'b1100,  1,   0, 384};
        vecs[7] = '{4'b1001, 32, 192, 192};

        rst = 1'b0; frame_tick = 1'b0; cpu_p2 = 1'b0;
        set_btn(4'hF);
        repeat (2) @(negedge clk_0);
        check_reset("por");
        frame_tick = 1'b1;
        @(negedge clk_0) frame_tick = 1'b0;
        check_reset("por_tick");

        // Arming: a held button before arm completion must not start the game.
        rst = 1'b1;
        up_p1 = 1'b0;
        repeat (30) @(negedge clk_0);
        check("arm_hold_phase", phase, 0);
        up_p1 = 1'b1;
        repeat (15) @(negedge clk_0);
        check("armed_idle_phase", phase, 0);
        up_p1 = 1'b0;
        @(negedge clk_0) up_p1 = 1'b1;
        check("serve_enter_phase", phase, 1);

        // Paddle vectors during SERVE: stepping, clamping, both-pressed hold.
        for (int i = 0; i < 8; i++) begin
            set_btn(vecs[i].btn);
            repeat (vecs[i].n) tick();
            set_btn(4'hF);
            check($sformatf("vec%0d_pdl1", i), pdl1_y, vecs[i].e1);
            check($sformatf("vec%0d_pdl2", i), pdl2_y, vecs[i].e2);
            check($sformatf("vec%0d_hidden", i), ball_shown, 0);
        end
        repeat (9) tick();
        check("serve_119_phase", phase, 1);
        tick();
        check("play_phase", phase, 2);
        check("play_shown", ball_shown, 1);
        check("play_ball_x", ball_x, 312);
        check("play_ball_y", ball_y, 232);

        // Centred hit on the left paddle at tick 69.
        base = n_p1 + n_p2;
        repeat (68) tick();
        check("centre_t68_x", ball_x, 40);
        tick();
        check("centre_hit_x", ball_x, 36);
        check("centre_hit_y", ball_y, 232);
        tick();
        check("centre_after_x", ball_x, 40);
        check("centre_after_y", ball_y, 232);
        @(negedge clk_0);
        check("centre_no_point", n_p1 + n_p2 - base, 0);

        pulse_reset("midplay");

        // Edge deflection: pdl1 at 150 gives off = +42 -> vy 5 down, then bottom wall.
        arm_and_serve("edge");
        up_p1 = 1'b0;
        repeat (7) tick();
        up_p1 = 1'b1;
        check("edge_pdl1", pdl1_y, 150);
        repeat (113) tick();
        check("edge_play_phase", phase, 2);
        repeat (69) tick();
        check("edge_hit_x", ball_x, 36);
        check("edge_hit_y", ball_y, 232);
        tick();
        check("edge_k1_x", ball_x, 40);
        check("edge_k1_y", ball_y, 237);
        repeat (46) tick();
        check("edge_wall_y", ball_y, 464);
        check("edge_wall_x", ball_x, 224);
        tick();
        check("edge_up_y", ball_y, 459);

        pulse_reset("edge_rst");

        // Three misses by P1 with MAX_SCORE = 3.
        arm_and_serve("miss");
        up_p1 = 1'b0;
        for (int s = 1; s <= 3; s++) begin
            repeat (120) tick();
            check($sformatf("miss%0d_play", s), phase, 2);
            repeat (78) tick();
            check($sformatf("miss%0d_x0", s), ball_x, 0);
            tick();
            check($sformatf("miss%0d_point", s), point_p2, 1);
            check($sformatf("miss%0d_score_p2", s), score_p2, s);
            check($sformatf("miss%0d_score_p1", s), score_p1, 0);
            check($sformatf("miss%0d_hidden", s), ball_shown, 0);
            check($sformatf("miss%0d_recentre", s), ball_x, 312);
            check($sformatf("miss%0d_phase", s), phase, (s == 3) ? 3 : 1);
            @(negedge clk_0);
            check($sformatf("miss%0d_pulse_width", s), point_p2, 0);
        end
        repeat (5) @(negedge clk_0);
        tick();
        check("over_hold_phase", phase, 3);
        check("over_hold_score", score_p2, 3);
        check("over_hold_pdl1", pdl1_y, 0);
        check("over_hidden", ball_shown, 0);
        up_p1 = 1'b1;
        @(negedge clk_0) down_p2 = 1'b0;
        @(negedge clk_0) down_p2 = 1'b1;
        check("over_exit_phase", phase, 0);
        check("over_exit_scores", {score_p1, score_p2}, 0);

        // CPU paddle: approach without overshoot, then track a deflected ball into the clamp.
        arm_and_serve("cpu");
        check("cpu_pdl1_start", pdl1_y, 192);
        up_p1 = 1'b0;
        repeat (7) tick();
        up_p1 = 1'b1;
        down_p2 = 1'b0;
        repeat (32) tick();
        down_p2 = 1'b1;
        check("cpu_pre_pdl2", pdl2_y, 384);
        up_p2 = 1'b0;
        tick();
        up_p2 = 1'b1;
        check("cpu_pre2_pdl2", pdl2_y, 378);
        cpu_p2 = 1'b1;
        tick();
        check("cpu_step1", pdl2_y, 374);
        repeat (45) tick();
        check("cpu_step46", pdl2_y, 194);
        tick();
        check("cpu_land", pdl2_y, 192);
        tick();
        check("cpu_no_overshoot", pdl2_y, 192);
        repeat (32) tick();
        check("cpu_play_phase", phase, 2);
        up_p2 = 1'b0;
        bad = 0;
        prev = pdl2_y;
        for (int k = 1; k <= 126; k++) begin
            tick();
            d = int'(pdl2_y) - prev;
            if (d > 4 || d < -4 || pdl2_y > 384) bad++;
            prev = pdl2_y;
            if (k == 69) begin
                check("cpu_hit_x", ball_x, 36);
                check("cpu_hit_pdl2", pdl2_y, 192);
            end
            if (k == 118) check("cpu_k49_pdl2", pdl2_y, 384);
            if (k == 125) check("cpu_k56_pdl2", pdl2_y, 384);
            if (k == 126) check("cpu_k57_pdl2", pdl2_y, 380);
        end
        check("cpu_step_bound", bad, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
